// File: rtl/everloop_pkg.sv
// everloop_pkg: shared constants for the everloop frame scheduler.
//   FRAME_BYTES   bytes streamed per frame (NUM_LEDS * BYTES_PER_LED)
//   BANK_BIT      RAM address bit selecting the display bank
//   LAST_IDX      byte index of the final byte of a frame
//   ST_*          scheduler state encoding
package everloop_pkg;

  localparam int NUM_LEDS       = 35;
  localparam int BYTES_PER_LED  = 4;
  localparam int FRAME_BYTES    = NUM_LEDS * BYTES_PER_LED;
  localparam int MEM_ADDR_WIDTH = 9;
  localparam int BANK_BIT       = MEM_ADDR_WIDTH - 1;
  localparam int PERIOD_WIDTH   = 24;
  localparam int LATCH_WIDTH    = 16;

  typedef logic [BANK_BIT-1:0] byte_idx_t;

  localparam byte_idx_t LAST_IDX = byte_idx_t'(FRAME_BYTES - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_RDWAIT  = 3'd2;
  localparam logic [2:0] ST_PRESENT = 3'd3;
  localparam logic [2:0] ST_LATCH   = 3'd4;

endpackage

// File: rtl/everloop_frame_timer.sv
// everloop_frame_timer: frame-period down-counter and latch-interval counter.
// Ports:
//   clk, resetn     clock, synchronous active-low reset
//   start           frame start: reload period counter from frame_period
//   frame_period    cycles between frame starts (0 = back-to-back)
//   latch_load      latch entry: load latch counter from latch_cycles
//   latch_cycles    latch interval length (0 behaves as 1)
//   period_zero     period counter is 0 (next frame may start)
//   latch_done      current cycle is the last cycle of the latch interval
module everloop_frame_timer
  import everloop_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [PERIOD_WIDTH-1:0] frame_period,
  input  logic                    latch_load,
  input  logic [LATCH_WIDTH-1:0]  latch_cycles,
  output logic                    period_zero,
  output logic                    latch_done
);

  localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);
  localparam logic [LATCH_WIDTH-1:0]  LATCH_ONE  = LATCH_WIDTH'(1);

  logic [PERIOD_WIDTH-1:0] period_cnt;
  logic [LATCH_WIDTH-1:0]  latch_cnt;

  // Reloading with N-1 on the start cycle makes the next start land exactly
  // N cycles later; the latch counter likewise counts the entry cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      period_cnt <= '0;
      latch_cnt  <= '0;
    end else begin
      if (start)
        period_cnt <= (frame_period == '0) ? '0 : frame_period - PERIOD_ONE;
      else if (period_cnt != '0)
        period_cnt <= period_cnt - PERIOD_ONE;

      if (latch_load)
        latch_cnt <= (latch_cycles == '0) ? '0 : latch_cycles - LATCH_ONE;
      else if (latch_cnt != '0)
        latch_cnt <= latch_cnt - LATCH_ONE;
    end
  end

  assign period_zero = (period_cnt == '0);
  assign latch_done  = (latch_cnt == '0);

endmodule

// File: rtl/everloop_frame_sched.sv
// everloop_frame_sched: streams one LED frame per period from the dual-bank
// LED RAM to the everloop serializer, inserts the latch interval after each
// frame and swaps the displayed bank only at frame boundaries.
// Optional feature macro: EVERLOOP_BRIGHTNESS_EN (scale bytes by brightness).
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   frame_en             enable periodic streaming
//   frame_period         cycles from frame start to frame start (0 = back-to-back)
//   latch_cycles         ser_latch high time after a frame (0 behaves as 1)
//   swap_req / swap_ack  bank toggle request (level) / toggle pulse
//   disp_bank            bank currently displayed
//   brightness           global scale (only with EVERLOOP_BRIGHTNESS_EN)
//   ram_en/ram_adr/ram_dat  RAM read port, data one cycle after ram_en
//   ser_req/ser_ack/ser_dat serializer byte handshake (ack 2 cycles after req)
//   ser_latch            holds serializer in latch/reset
//   frame_done           pulse on the last cycle of the latch interval
//   overrun              sticky: period elapsed while a frame was active
// The latch interval is max(latch_cycles,1) cycles; frame_done, the bank swap
// and swap_ack happen on its final cycle.
module everloop_frame_sched
  import everloop_pkg::*;
(
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      frame_en,
  input  logic [PERIOD_WIDTH-1:0]   frame_period,
  input  logic [LATCH_WIDTH-1:0]    latch_cycles,
  input  logic                      swap_req,
  output logic                      swap_ack,
  output logic                      disp_bank,
  input  logic [7:0]                brightness,
  output logic                      ram_en,
  output logic [MEM_ADDR_WIDTH-1:0] ram_adr,
  input  logic [7:0]                ram_dat,
  input  logic                      ser_req,
  output logic                      ser_ack,
  output logic [7:0]                ser_dat,
  output logic                      ser_latch,
  output logic                      frame_done,
  output logic                      overrun
);

`ifdef EVERLOOP_BRIGHTNESS_EN
  // (d * (b+1)) >> 8: b=255 passes d unchanged, b=0 yields 0.
  function automatic logic [7:0] scale_byte(input logic [7:0] d, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(d) * (16'(b) + 16'd1);
    return 8'(prod >> 8);
  endfunction
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  logic [2:0] state;
  byte_idx_t  byte_idx;
  logic [7:0] dat_p1;
  logic       bank;
  logic       ovr;

  logic period_zero;
  logic latch_done;
  logic start;
  logic accept;
  logic last_byte;
  logic latch_load;
  logic frame_end;

  assign start      = (state == ST_IDLE) && frame_en && period_zero;
  assign accept     = (state == ST_FETCH) && ser_req;
  assign last_byte  = (byte_idx == LAST_IDX);
  assign latch_load = (state == ST_PRESENT) && last_byte;
  assign frame_end  = (state == ST_LATCH) && latch_done;

  everloop_frame_timer u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .frame_period (frame_period),
    .latch_load   (latch_load),
    .latch_cycles (latch_cycles),
    .period_zero  (period_zero),
    .latch_done   (latch_done)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      byte_idx <= '0;
      bank     <= 1'b0;
      ovr      <= 1'b0;
      dat_p1   <= '0;
    end else begin
      // Period counter hitting zero inside a frame means the frame is too
      // long for the configured period.
      if (period_zero && (state != ST_IDLE) && (frame_period != '0))
        ovr <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            byte_idx <= '0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (ser_req)
            state <= ST_RDWAIT;
        end
        // Stage p1: RAM data arrives, register (optionally scaled) byte.
        ST_RDWAIT: begin
`ifdef EVERLOOP_BRIGHTNESS_EN
          dat_p1 <= scale_byte(ram_dat, brightness);
`else
          dat_p1 <= ram_dat;
`endif
          state  <= ST_PRESENT;
        end
        // Stage p2: byte presented with ser_ack.
        ST_PRESENT: begin
          if (last_byte) begin
            state <= ST_LATCH;
          end else begin
            byte_idx <= byte_idx + byte_idx_t'(1);
            state    <= ST_FETCH;
          end
        end
        ST_LATCH: begin
          if (latch_done) begin
            state <= ST_IDLE;
            if (swap_req)
              bank <= ~bank;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ram_en     = accept;
  assign ram_adr    = {bank, byte_idx};
  assign ser_ack    = (state == ST_PRESENT);
  assign ser_dat    = dat_p1;
  assign ser_latch  = (state == ST_IDLE) || (state == ST_LATCH);
  assign frame_done = frame_end;
  assign swap_ack   = frame_end && swap_req;
  assign disp_bank  = bank;
  assign overrun    = ovr;

endmodule

// File: tb/tb_everloop_frame_sched.sv
// tb_everloop_frame_sched: randomized bench for everloop_frame_sched with a
// RAM model, a serializer request generator and a scoreboard that predicts
// the byte stream, addresses, latch length and bank swaps of every frame.
module tb_everloop_frame_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        frame_en;
  logic [23:0] frame_period;
  logic [15:0] latch_cycles;
  logic        swap_req;
  logic        swap_ack;
  logic        disp_bank;
  logic [7:0]  brightness;
  logic        ram_en;
  logic [8:0]  ram_adr;
  logic [7:0]  ram_dat;
  logic        ser_req;
  logic        ser_ack;
  logic [7:0]  ser_dat;
  logic        ser_latch;
  logic        frame_done;
  logic        overrun;

  always #5 clk = ~clk;

  everloop_frame_sched dut (
    .clk(clk), .resetn(resetn), .frame_en(frame_en), .frame_period(frame_period),
    .latch_cycles(latch_cycles), .swap_req(swap_req), .swap_ack(swap_ack),
    .disp_bank(disp_bank), .brightness(brightness), .ram_en(ram_en),
    .ram_adr(ram_adr), .ram_dat(ram_dat), .ser_req(ser_req), .ser_ack(ser_ack),
    .ser_dat(ser_dat), .ser_latch(ser_latch), .frame_done(frame_done),
    .overrun(overrun)
  );

  // LED RAM model: one-cycle read latency.
  logic [7:0] mem [0:511];
  always @(posedge clk) if (ram_en) ram_dat <= mem[ram_adr];

  int checks = 0;
  int passed = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model state
  logic [7:0] exp_q [$];
  bit  mbank = 1'b0;
  int  exp_idx = 0, frames = 0, total_acks = 0, cyc = 0;
  int  last_ack_cyc = 0, latch_hi = 0;
  bit  in_latch = 0, chk_bank = 0, need_push = 1, req_d1 = 0, req_d2 = 0;
  int  req_mode = 0;

  function automatic logic [7:0] model_byte(input logic [7:0] raw);
`ifdef EVERLOOP_BRIGHTNESS_EN
    int p;
    p = int'(raw) * (int'(brightness) + 1);
    return 8'(p / 256);
`else
    return raw;
`endif
  endfunction

  task automatic push_frame();
    for (int i = 0; i < 140; i++) exp_q.push_back(mem[{mbank, 8'(i)}]);
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        exp_q.delete();
        mbank = 1'b0; exp_idx = 0; need_push = 1;
        in_latch = 0; chk_bank = 0; req_d1 = 0; req_d2 = 0;
      end else begin
        if (need_push) begin push_frame(); need_push = 0; end
        if (chk_bank) begin
          check(disp_bank == mbank, "disp_bank", int'(disp_bank), int'(mbank));
          chk_bank = 0;
        end
        if (ram_en)
          check(ram_adr == {mbank, 8'(exp_idx)}, "ram_adr", int'(ram_adr), int'({mbank, 8'(exp_idx)}));
        if (ser_ack) begin
          logic [7:0] raw, want;
          check(req_d2, "ack_latency", int'(req_d2), 1);
          check(!ser_latch, "latch_during_ack", int'(ser_latch), 0);
          check(exp_q.size() > 0, "ack_count", exp_idx + 1, 140);
          if (exp_q.size() > 0) begin
            raw  = exp_q.pop_front();
            want = model_byte(raw);
            check(ser_dat == want, "ser_dat", int'(ser_dat), int'(want));
            exp_idx++;
            total_acks++;
            if (exp_q.size() == 0) begin
              in_latch = 1; latch_hi = 0; last_ack_cyc = cyc;
            end
          end
        end else if (in_latch && ser_latch) begin
          latch_hi++;
        end
        if (frame_done) begin
          int lexp;
          lexp = (latch_cycles == 16'd0) ? 1 : int'(latch_cycles);
          check(in_latch && exp_q.size() == 0, "frame_bytes", exp_idx, 140);
          check(cyc - last_ack_cyc == lexp, "latch_len", cyc - last_ack_cyc, lexp);
          check(latch_hi == lexp, "latch_high", latch_hi, lexp);
          check(swap_ack == swap_req, "swap_ack", int'(swap_ack), int'(swap_req));
          if (swap_req) mbank = ~mbank;
          chk_bank = 1; frames++; in_latch = 0; exp_idx = 0;
          push_frame();
        end else if (swap_ack) begin
          check(frame_done, "swap_ack_stray", 0, 1);
        end
        req_d2 = req_d1;
        req_d1 = ser_req;
      end
    end
  end

  // Serializer request generator: fixed every 4 cycles or random gaps
  // (gap 1 gives back-to-back requests).
  initial begin
    int gap;
    ser_req = 1'b0;
    forever begin
      gap = (req_mode == 0) ? 4 : int'($urandom_range(1, 6));
      @(posedge clk); #1 ser_req = 1'b1;
      repeat (gap - 1) begin @(posedge clk); #1 ser_req = 1'b0; end
    end
  end

  task automatic wait_frames(input int n);
    int target;
    target = frames + n;
    for (int i = 0; i < 4000 * n && frames < target; i++) @(negedge clk);
    check(frames >= target, "frame_wait", frames, target);
  endtask

  task automatic wait_acks(input int k);
    for (int i = 0; i < 3000 && exp_idx < k; i++) @(negedge clk);
    check(exp_idx >= k, "ack_wait", exp_idx, k);
  endtask

  task automatic drive_at_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    int a;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 140; i++) mem[i] = 8'(i);
    mem[256] = 8'd200;
    mem[300] = 8'd200;
    ram_dat = 8'd0;
    resetn = 1'b0; frame_en = 1'b0; frame_period = 24'd0; latch_cycles = 16'd10;
    swap_req = 1'b0; brightness = 8'd255;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check(ser_latch == 1'b1, "rst_ser_latch", int'(ser_latch), 1);
    check(disp_bank == 1'b0, "rst_disp_bank", int'(disp_bank), 0);
    check(ser_ack == 1'b0, "rst_ser_ack", int'(ser_ack), 0);
    check(ram_en == 1'b0, "rst_ram_en", int'(ram_en), 0);
    check(ram_adr == 9'd0, "rst_ram_adr", int'(ram_adr), 0);
    check(ser_dat == 8'd0, "rst_ser_dat", int'(ser_dat), 0);
    check(frame_done == 1'b0, "rst_frame_done", int'(frame_done), 0);
    check(swap_ack == 1'b0, "rst_swap_ack", int'(swap_ack), 0);
    check(overrun == 1'b0, "rst_overrun", int'(overrun), 0);
    drive_at_edge(); resetn = 1'b1;

    // Back-to-back frames, bank 0 = 0..139, req every 4 cycles, latch 10
    frame_en = 1'b1;
    wait_frames(2);
    check(overrun == 1'b0, "overrun_period0", int'(overrun), 0);

    // Random requests, swap requested mid-frame, varied latch lengths
    req_mode = 1;
    for (int f = 0; f < 4; f++) begin
      wait_acks(30);
      drive_at_edge(); swap_req = (f == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      wait_frames(1);
      drive_at_edge(); swap_req = 1'b0;
      latch_cycles = (f == 0) ? 16'd0 : (f == 1) ? 16'd1 : 16'($urandom_range(2, 8));
    end
    check(overrun == 1'b0, "overrun_still0", int'(overrun), 0);

    // Period shorter than the frame
    req_mode = 0;
    drive_at_edge(); latch_cycles = 16'd10; frame_period = 24'd500;
    wait_frames(2);
    check(overrun == 1'b1, "overrun_set", int'(overrun), 1);
    drive_at_edge(); frame_period = 24'd0;
    wait_frames(1);
    check(overrun == 1'b1, "overrun_sticky", int'(overrun), 1);

    // frame_en dropped mid-frame: frame completes, then stays idle
    req_mode = 1;
    wait_acks(50);
    drive_at_edge(); frame_en = 1'b0;
    wait_frames(1);
    a = total_acks;
    repeat (150) @(negedge clk);
    check(total_acks == a, "idle_no_ack", total_acks, a);
    check(ser_latch == 1'b1, "idle_latch", int'(ser_latch), 1);

    // Reset at byte 70 while displaying bank 1
    drive_at_edge(); frame_en = 1'b1;
    if (mbank == 1'b0) begin
      drive_at_edge(); swap_req = 1'b1;
      wait_frames(1);
      drive_at_edge(); swap_req = 1'b0;
    end
    check(disp_bank == 1'b1, "pre_reset_bank", int'(disp_bank), 1);
    wait_acks(70);
    drive_at_edge(); resetn = 1'b0;
    drive_at_edge();
    check(ser_latch == 1'b1, "mid_rst_latch", int'(ser_latch), 1);
    check(ser_ack == 1'b0, "mid_rst_ack", int'(ser_ack), 0);
    check(disp_bank == 1'b0, "mid_rst_bank", int'(disp_bank), 0);
    check(frame_done == 1'b0, "mid_rst_done", int'(frame_done), 0);
    check(overrun == 1'b0, "mid_rst_overrun", int'(overrun), 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    wait_frames(1);

    // Brightness scaling on bank 1 (contains 200s)
    drive_at_edge(); swap_req = 1'b1;
    wait_acks(20);
    drive_at_edge(); frame_en = 1'b0;
    wait_frames(1);
    drive_at_edge(); swap_req = 1'b0; brightness = 8'd127; frame_en = 1'b1;
    wait_acks(20);
    drive_at_edge(); frame_en = 1'b0;
    wait_frames(1);
    drive_at_edge(); brightness = 8'd255; frame_en = 1'b1;
    wait_frames(1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
